// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared ALU modes, mux codes and register-file constants for the LC-3 datapath
package lc3_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_AND   = 3'b001,
        ALU_NOT   = 3'b010,
        ALU_PASS  = 3'b011,
        ALU_MUL   = 3'b100,
        ALU_SHL   = 3'b101,
        ALU_SAR   = 3'b110,
        ALU_PASS2 = 3'b111
    } aluk_e;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;
    localparam logic [1:0] PCMUX_HOLD = 2'b11;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [2:0] CC_RESET  = 3'b010;
    localparam int         GPR_COUNT = 8;
    localparam int         REG_IDX_W = 3;

endpackage

// File: rtl/lc3_mul_unit.sv
// rtl/lc3_mul_unit.sv - iterative shift-add multiplier with busy/done handshake
module lc3_mul_unit
    import lc3_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_e;

    mul_state_e        state, next_state;
    logic [DATA_W-1:0] mcand, mplier, acc;
    logic [CNT_W-1:0]  cnt;
    logic              accept;

    assign accept  = (state == MUL_IDLE) && start && MUL_EN;
    assign product = acc;

    always_ff @(posedge clk) begin
        if (!resetn) state <= MUL_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            MUL_IDLE: if (accept) next_state = MUL_RUN;
            MUL_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(DATA_W - 1)) next_state = MUL_DONE;
            end
            MUL_DONE: begin
                done       = 1'b1;
                next_state = MUL_IDLE;
            end
            default: next_state = MUL_IDLE;
        endcase
    end

    // The accumulator doubles as the product register: it only moves while running.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL_RUN) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lc3_datapath_param.sv
// rtl/lc3_datapath_param.sv - parametrised LC-3 datapath with extended ALU and multiplier
module lc3_datapath_param
    import lc3_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LED_W  = 12,
    parameter int MUL_EN = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              LD_IR,
    input  logic              LD_PC,
    input  logic              LD_REG,
    input  logic              LD_BEN,
    input  logic              LD_CC,
    input  logic              LD_LED,
    input  logic              GatePC,
    input  logic              GateMDR,
    input  logic              GateALU,
    input  logic              GateMARMUX,
    input  logic [1:0]        PCMUX,
    input  logic [1:0]        ADDR2MUX,
    input  logic [2:0]        ALUK,
    input  logic              DRMUX,
    input  logic              SR1MUX,
    input  logic              SR2MUX,
    input  logic              ADDR1MUX,
    input  logic              MIO_EN,
    input  logic              ALU_start,
    input  logic [DATA_W-1:0] Data_to_CPU,
    output logic              ALU_busy,
    output logic              ALU_done,
    output logic [DATA_W-1:0] output_MAR,
    output logic [DATA_W-1:0] output_MDR,
    output logic [DATA_W-1:0] output_IR,
    output logic [DATA_W-1:0] output_PC,
    output logic [2:0]        output_CC,
    output logic              output_BEN,
    output logic [LED_W-1:0]  output_LED,
    output logic              bus_conflict
);

    logic [DATA_W-1:0]    pc, mar, mdr, ir;
    logic [DATA_W-1:0]    gpr [GPR_COUNT];
    logic [LED_W-1:0]     led;
    logic [2:0]           cc;
    logic                 ben;

    logic [REG_IDX_W-1:0] dr_idx, sr1_idx, sr2_idx;
    logic [DATA_W-1:0]    sr1_val, sr2_val;
    logic [DATA_W-1:0]    sext5, sext6, sext9, sext11;
    logic [DATA_W-1:0]    addr1, addr2, addr_sum;
    logic [DATA_W-1:0]    alu_b, alu_out, mul_product;
    logic [DATA_W-1:0]    bus, pc_next;
    logic [2:0]           cc_next;
    logic [2:0]           gate_cnt;

    assign dr_idx  = DRMUX  ? 3'd7 : ir[11:9];
    assign sr1_idx = SR1MUX ? ir[8:6] : ir[11:9];
    assign sr2_idx = ir[2:0];
    assign sr1_val = gpr[sr1_idx];
    assign sr2_val = gpr[sr2_idx];

    assign sext5  = {{(DATA_W-5){ir[4]}},   ir[4:0]};
    assign sext6  = {{(DATA_W-6){ir[5]}},   ir[5:0]};
    assign sext9  = {{(DATA_W-9){ir[8]}},   ir[8:0]};
    assign sext11 = {{(DATA_W-11){ir[10]}}, ir[10:0]};

    assign addr1 = ADDR1MUX ? sr1_val : pc;

    always_comb begin
        addr2 = '0;
        case (ADDR2MUX)
            ADDR2_ZERO:  addr2 = '0;
            ADDR2_OFF6:  addr2 = sext6;
            ADDR2_OFF9:  addr2 = sext9;
            ADDR2_OFF11: addr2 = sext11;
            default:     addr2 = '0;
        endcase
    end

    assign addr_sum = addr1 + addr2;
    assign alu_b    = SR2MUX ? sext5 : sr2_val;

    lc3_mul_unit #(
        .DATA_W (DATA_W),
        .MUL_EN (MUL_EN != 0)
    ) u_mul (
        .clk     (Clk),
        .resetn  (Reset),
        .start   (ALU_start && (ALUK == ALU_MUL)),
        .a       (sr1_val),
        .b       (alu_b),
        .busy    (ALU_busy),
        .done    (ALU_done),
        .product (mul_product)
    );

    always_comb begin
        alu_out = sr1_val;
        case (ALUK)
            ALU_ADD:   alu_out = sr1_val + alu_b;
            ALU_AND:   alu_out = sr1_val & alu_b;
            ALU_NOT:   alu_out = ~sr1_val;
            ALU_PASS:  alu_out = sr1_val;
            ALU_MUL:   alu_out = mul_product;
            ALU_SHL:   alu_out = {sr1_val[DATA_W-2:0], 1'b0};
            ALU_SAR:   alu_out = {sr1_val[DATA_W-1], sr1_val[DATA_W-1:1]};
            ALU_PASS2: alu_out = sr1_val;
            default:   alu_out = sr1_val;
        endcase
    end

    // Priority only matters when the controller misbehaves; bus_conflict flags it.
    always_comb begin
        bus = '0;
        if (GateMDR)         bus = mdr;
        else if (GateALU)    bus = alu_out;
        else if (GatePC)     bus = pc;
        else if (GateMARMUX) bus = addr_sum;
    end

    assign gate_cnt     = {2'b00, GatePC} + {2'b00, GateMDR} + {2'b00, GateALU} + {2'b00, GateMARMUX};
    assign bus_conflict = (gate_cnt > 3'd1);

    always_comb begin
        pc_next = pc;
        case (PCMUX)
            PCMUX_INC:  pc_next = pc + 1'b1;
            PCMUX_BUS:  pc_next = bus;
            PCMUX_ADDR: pc_next = addr_sum;
            PCMUX_HOLD: pc_next = pc;
            default:    pc_next = pc;
        endcase
    end

    always_comb begin
        if (bus[DATA_W-1])   cc_next = 3'b100;
        else if (bus == '0)  cc_next = 3'b010;
        else                 cc_next = 3'b001;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc  <= '0;
            mar <= '0;
            mdr <= '0;
            ir  <= '0;
            led <= '0;
            cc  <= CC_RESET;
            ben <= 1'b0;
            for (int i = 0; i < GPR_COUNT; i++) gpr[i] <= '0;
        end else begin
            if (LD_PC)  pc  <= pc_next;
            if (LD_MAR) mar <= bus;
            if (LD_MDR) mdr <= MIO_EN ? Data_to_CPU : bus;
            if (LD_IR)  ir  <= bus;
            if (LD_REG) gpr[dr_idx] <= bus;
            if (LD_CC)  cc  <= cc_next;
            if (LD_BEN) ben <= |(ir[11:9] & cc);
            led <= LD_LED ? ir[LED_W-1:0] : '0;
        end
    end

    assign output_PC  = pc;
    assign output_MAR = mar;
    assign output_MDR = mdr;
    assign output_IR  = ir;
    assign output_CC  = cc;
    assign output_BEN = ben;
    assign output_LED = led;

endmodule
